// File: rtl/cache_defs.sv
// rtl/cache_defs.sv - shared state encoding and address field layout for data_cache
package cache_defs;

    localparam int ADDR_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCKS     = 1 << INDEX_W;
    localparam int BLOCK_W    = 8 << OFFSET_W;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int TAG_LSB    = OFFSET_W + INDEX_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } cache_state_t;

endpackage

// File: rtl/cache_byte_sel.sv
// rtl/cache_byte_sel.sv - byte read mux and byte-lane write merge for one cache block
module cache_byte_sel
    import cache_defs::*;
(
    input  logic [BLOCK_W-1:0]  block,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [7:0]          wbyte,
    output logic [7:0]          rbyte,
    output logic [BLOCK_W-1:0]  merged
);

    always_comb begin
        rbyte  = block[{offset, 3'b000} +: 8];
        merged = block;
        merged[{offset, 3'b000} +: 8] = wbyte;
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate byte cache over a block memory
module data_cache
    import cache_defs::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [BLOCK_W-1:0] data_arr [BLOCKS];
    logic [TAG_W-1:0]   tag_arr  [BLOCKS];
    logic [BLOCKS-1:0]  valid;
    logic [BLOCKS-1:0]  dirty;
    logic [BLOCK_W-1:0] refill;

    cache_state_t state, next_state;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] offset;
    logic                hit;
    logic                write_hit;
    logic [7:0]          rbyte;
    logic [BLOCK_W-1:0]  merged;

    assign addr_tag = ADDRESS[ADDR_W-1:TAG_LSB];
    assign idx      = ADDRESS[TAG_LSB-1:INDEX_LSB];
    assign offset   = ADDRESS[OFFSET_W-1:0];
    assign hit      = valid[idx] && (tag_arr[idx] == addr_tag);

    cache_byte_sel u_byte_sel (
        .block  (data_arr[idx]),
        .offset (offset),
        .wbyte  (WRITEDATA),
        .rbyte  (rbyte),
        .merged (merged)
    );

    always_comb begin
        next_state    = state;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        READDATA      = 8'h00;
        write_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (READ || WRITE) begin
                    if (hit) begin
                        // A simultaneous READ and WRITE is serviced as a store.
                        if (WRITE) write_hit = 1'b1;
                        else       READDATA  = rbyte;
                    end else begin
                        BUSYWAIT   = 1'b1;
                        next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
                    end
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_arr[idx], idx};
                MEM_WRITEDATA = data_arr[idx];
                if (!MEM_BUSYWAIT) next_state = FETCH;
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[ADDR_W-1:OFFSET_W];
                if (!MEM_BUSYWAIT) next_state = UPDATE;
            end
            UPDATE: begin
                BUSYWAIT   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next_state;
            if (write_hit) dirty[idx] <= 1'b1;
            if (state == UPDATE) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // Data, tags and the refill buffer are qualified by valid, so they need no reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == FETCH && !MEM_BUSYWAIT) refill <= MEM_READDATA;
            if (write_hit) data_arr[idx] <= merged;
            if (state == UPDATE) begin
                data_arr[idx] <= refill;
                tag_arr[idx]  <= addr_tag;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache with a latency memory model
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;

    int tests = 0;
    int fails = 0;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: busy for mem_lat cycles of a request, then completes on the next one.
    logic [31:0] mem [64];
    bit          mem_ready = 1'b0;
    int          mem_lat = 2;
    int          mem_cnt = 0;

    always @(negedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[0]  = 32'h44332211;
            mem[8]  = 32'h88776655;
            mem[63] = 32'hDDCCBBAA;
            mem_ready = 1'b1;
        end
        if (RESET || !(MEM_READ || MEM_WRITE)) begin
            mem_cnt = 0;
            MEM_BUSYWAIT = 1'b0;
        end else if (mem_cnt < mem_lat) begin
            mem_cnt++;
            MEM_BUSYWAIT = 1'b1;
        end else begin
            mem_cnt = 0;
            MEM_BUSYWAIT = 1'b0;
            if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
            else           MEM_READDATA = mem[MEM_ADDRESS];
        end
    end

    logic [7:0]  obs_rdata;
    int          obs_stall;
    logic        obs_rd_seen, obs_wr_seen, obs_both;
    logic [5:0]  obs_rd_addr, obs_wr_addr;
    logic [31:0] obs_wr_data;

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        obs_stall = 0; obs_rd_seen = 0; obs_wr_seen = 0; obs_both = 0;
        obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
        @(posedge CLK); #1;
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
        #2;
        while (BUSYWAIT && obs_stall < 60) begin
            if (MEM_READ && MEM_WRITE) obs_both = 1;
            if (MEM_READ && !obs_rd_seen) begin obs_rd_seen = 1; obs_rd_addr = MEM_ADDRESS; end
            if (MEM_WRITE && !obs_wr_seen) begin
                obs_wr_seen = 1; obs_wr_addr = MEM_ADDRESS; obs_wr_data = MEM_WRITEDATA;
            end
            obs_stall++;
            @(posedge CLK); #3;
        end
        obs_rdata = READDATA;
        @(posedge CLK); #1;
        READ = 0; WRITE = 0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1; READ = 0; WRITE = 0;
        @(posedge CLK); #1;
        RESET = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        tests++; if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL reset_busywait: got %b want 0", BUSYWAIT); end
        tests++; if (MEM_READ !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", MEM_READ); end
        tests++; if (MEM_WRITE !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b want 0", MEM_WRITE); end
        tests++; if (READDATA !== 8'h00) begin fails++; $display("FAIL reset_readdata: got %h want 00", READDATA); end
        tests++; if (MEM_ADDRESS !== 6'h00) begin fails++; $display("FAIL reset_mem_address: got %h want 00", MEM_ADDRESS); end
        tests++; if (MEM_WRITEDATA !== 32'h0) begin fails++; $display("FAIL reset_mem_writedata: got %h want 0", MEM_WRITEDATA); end
    endtask

    task automatic test_clean_read_miss();
        access(1, 0, 8'h00, 8'h00);
        tests++; if (obs_rdata !== 8'h11) begin fails++; $display("FAIL cold_read_data: got %h want 11", obs_rdata); end
        tests++; if (obs_stall !== 5) begin fails++; $display("FAIL cold_read_stall: got %0d want 5", obs_stall); end
        tests++; if (obs_rd_seen !== 1'b1 || obs_rd_addr !== 6'h00) begin fails++; $display("FAIL cold_read_fetch: got seen=%b addr=%h want 1/00", obs_rd_seen, obs_rd_addr); end
        tests++; if (obs_wr_seen !== 1'b0) begin fails++; $display("FAIL cold_read_no_wb: got %b want 0", obs_wr_seen); end
    endtask

    task automatic test_read_hit();
        access(1, 0, 8'h03, 8'h00);
        tests++; if (obs_rdata !== 8'h44) begin fails++; $display("FAIL hit_read_data: got %h want 44", obs_rdata); end
        tests++; if (obs_stall !== 0 || obs_rd_seen !== 1'b0) begin fails++; $display("FAIL hit_read_stall: got stall=%0d rd=%b want 0/0", obs_stall, obs_rd_seen); end
    endtask

    task automatic test_write_hit();
        access(0, 1, 8'h01, 8'hAA);
        tests++; if (obs_stall !== 0 || obs_rdata !== 8'h00) begin fails++; $display("FAIL write_hit: got stall=%0d rdata=%h want 0/00", obs_stall, obs_rdata); end
        access(1, 0, 8'h01, 8'h00);
        tests++; if (obs_rdata !== 8'hAA) begin fails++; $display("FAIL write_hit_readback: got %h want aa", obs_rdata); end
    endtask

    task automatic test_dirty_miss();
        access(1, 0, 8'h20, 8'h00);
        tests++; if (obs_wr_seen !== 1'b1 || obs_wr_addr !== 6'h00) begin fails++; $display("FAIL wb_addr: got seen=%b addr=%h want 1/00", obs_wr_seen, obs_wr_addr); end
        tests++; if (obs_wr_data !== 32'h4433AA11) begin fails++; $display("FAIL wb_data: got %h want 4433aa11", obs_wr_data); end
        tests++; if (obs_rd_addr !== 6'h08) begin fails++; $display("FAIL wb_fetch_addr: got %h want 08", obs_rd_addr); end
        tests++; if (obs_rdata !== 8'h55 || obs_stall !== 8) begin fails++; $display("FAIL wb_result: got data=%h stall=%0d want 55/8", obs_rdata, obs_stall); end
        tests++; if (obs_both !== 1'b0) begin fails++; $display("FAIL wb_rd_wr_overlap: got %b want 0", obs_both); end
        // Refilled block must be clean, and the written-back byte must now live in memory.
        access(1, 0, 8'h01, 8'h00);
        tests++; if (obs_wr_seen !== 1'b0 || obs_stall !== 5) begin fails++; $display("FAIL clean_after_update: got wb=%b stall=%0d want 0/5", obs_wr_seen, obs_stall); end
        tests++; if (obs_rdata !== 8'hAA) begin fails++; $display("FAIL wb_persisted: got %h want aa", obs_rdata); end
    endtask

    task automatic test_read_write_both();
        access(1, 0, 8'h21, 8'h00);
        tests++; if (obs_rdata !== 8'h66 || obs_wr_seen !== 1'b0) begin fails++; $display("FAIL refetch_tag1: got data=%h wb=%b want 66/0", obs_rdata, obs_wr_seen); end
        access(1, 1, 8'h21, 8'h99);
        tests++; if (obs_rdata !== 8'h00 || obs_stall !== 0) begin fails++; $display("FAIL both_is_write: got data=%h stall=%0d want 00/0", obs_rdata, obs_stall); end
        access(1, 0, 8'h01, 8'h00);
        tests++; if (obs_wr_addr !== 6'h08 || obs_wr_data !== 32'h88779955) begin fails++; $display("FAIL both_wb: got addr=%h data=%h want 08/88779955", obs_wr_addr, obs_wr_data); end
        tests++; if (obs_rdata !== 8'hAA) begin fails++; $display("FAIL both_wb_refill: got %h want aa", obs_rdata); end
    endtask

    task automatic test_cold_write();
        do_reset();
        access(0, 1, 8'hFF, 8'h5C);
        tests++; if (obs_rd_addr !== 6'h3F || obs_wr_seen !== 1'b0 || obs_stall !== 5) begin fails++; $display("FAIL cold_write_miss: got addr=%h wb=%b stall=%0d want 3f/0/5", obs_rd_addr, obs_wr_seen, obs_stall); end
        access(1, 0, 8'hFF, 8'h00);
        tests++; if (obs_rdata !== 8'h5C) begin fails++; $display("FAIL cold_write_byte3: got %h want 5c", obs_rdata); end
        access(1, 0, 8'hFC, 8'h00);
        tests++; if (obs_rdata !== 8'hAA) begin fails++; $display("FAIL cold_write_byte0: got %h want aa", obs_rdata); end
        access(1, 0, 8'h1F, 8'h00);
        tests++; if (obs_wr_addr !== 6'h3F || obs_wr_data !== 32'h5CCCBBAA) begin fails++; $display("FAIL cold_write_dirty_wb: got addr=%h data=%h want 3f/5cccbbaa", obs_wr_addr, obs_wr_data); end
        tests++; if (obs_rd_addr !== 6'h07 || obs_rdata !== 8'h00 || obs_stall !== 8) begin fails++; $display("FAIL cold_write_refetch: got addr=%h data=%h stall=%0d want 07/00/8", obs_rd_addr, obs_rdata, obs_stall); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        mem_lat = 1000;
        @(posedge CLK); #1;
        READ = 1; ADDRESS = 8'h00;
        repeat (3) @(posedge CLK);
        #2;
        tests++; if (MEM_READ !== 1'b1 || BUSYWAIT !== 1'b1) begin fails++; $display("FAIL midfetch_pending: got rd=%b busy=%b want 1/1", MEM_READ, BUSYWAIT); end
        @(posedge CLK); #1;
        RESET = 1; READ = 0;
        @(posedge CLK); #1;
        RESET = 0;
        #2;
        tests++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0 || MEM_ADDRESS !== 6'h00) begin fails++; $display("FAIL midfetch_dropped: got rd=%b busy=%b addr=%h want 0/0/00", MEM_READ, BUSYWAIT, MEM_ADDRESS); end
        mem_lat = 2;
        access(1, 0, 8'h00, 8'h00);
        tests++; if (obs_rd_seen !== 1'b1 || obs_stall !== 5) begin fails++; $display("FAIL midfetch_remiss: got rd=%b stall=%0d want 1/5", obs_rd_seen, obs_stall); end
        tests++; if (obs_rdata !== 8'h11) begin fails++; $display("FAIL midfetch_remiss_data: got %h want 11", obs_rdata); end
    endtask

    initial begin
        test_reset();
        test_clean_read_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_read_write_both();
        test_cold_write();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
